// File: rtl/score_hud_ctrl.sv
// HUD score keeper: saturating score, once-per-frame double-dabble BCD conversion,
// digit font addressing and pixel compositing. Optional blink: `define SCORE_FLASH_EN.
module score_hud_ctrl #(
    parameter int          SCORE_W      = 14,
    parameter int          MAX_SCORE    = 9999,
    parameter int          DIGIT_X0     = 640,
    parameter int          DIGIT_Y0     = 118,
    parameter int          DIGIT_W      = 16,
    parameter int          DIGIT_H      = 24,
    parameter logic [23:0] DIGIT_RGB    = 24'hFFFF00,
    parameter int          FLASH_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               hit_pulse,
    input  logic [3:0]         hit_value,
    input  logic               score_clr,
    input  logic [9:0]         hsync,
    input  logic [9:0]         vsync,
    input  logic [23:0]        label_rgb,
    output logic [3:0]         font_digit,
    output logic [4:0]         font_row,
    output logic [3:0]         font_col,
    input  logic               font_pixel,
    output logic [23:0]        rgb,
    output logic [SCORE_W-1:0] score,
    output logic               conv_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH
    } conv_state_e;

    localparam int CNT_W   = $clog2(SCORE_W + 1);
    localparam int FIELD_W = 4 * DIGIT_W;

    conv_state_e        state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] shift_q, shift_d;
    logic [15:0]        acc_q, acc_d;
    logic [15:0]        disp_bcd_q, disp_bcd_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [23:0]        rgb_q, rgb_d;

    logic [SCORE_W:0]   score_sum;
    logic [15:0]        acc_adj;
    logic               digits_hidden;

    function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
        logic [15:0] res;
        for (int n = 0; n < 4; n++) begin
            if (bcd[4*n +: 4] >= 4'd5) res[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
            else                       res[4*n +: 4] = bcd[4*n +: 4];
        end
        return res;
    endfunction

    // Sum one bit wider than the score so the saturation compare sees the carry.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        score_sum = {1'b0, score_q} + (SCORE_W + 1)'(hit_value);
        score_d   = score_q;
        if (score_clr) begin
            score_d = '0;
        end else if (hit_pulse) begin
            if (score_sum > (SCORE_W + 1)'(MAX_SCORE)) score_d = SCORE_W'(MAX_SCORE);
            else                                       score_d = score_sum[SCORE_W-1:0];
        end
    end

    assign acc_adj = dabble_adjust(acc_q);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        disp_bcd_d = disp_bcd_q;
        conv_busy  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    shift_d   = score_q;
                    acc_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                conv_busy = 1'b1;
                acc_d     = {acc_adj[14:0], shift_q[SCORE_W-1]};
                shift_d   = {shift_q[SCORE_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_W'(SCORE_W - 1)) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                conv_busy  = 1'b1;
                disp_bcd_d = acc_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SCORE_FLASH_EN
    localparam int FLASH_W = ($clog2(FLASH_FRAMES + 1) < 3) ? 3 : $clog2(FLASH_FRAMES + 1);

    logic [FLASH_W-1:0] flash_q, flash_d;

    // A fresh value reaching the display restarts the blink; otherwise count frames down.
    always_comb begin
        flash_d = flash_q;
        if (state_q == ST_LATCH && acc_q != disp_bcd_q) flash_d = FLASH_W'(FLASH_FRAMES);
        else if (frame_start && flash_q != '0)          flash_d = flash_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flash_q <= '0;
        else     flash_q <= flash_d;
    end

    assign digits_hidden = (flash_q != '0) && flash_q[2];
`else
    assign digits_hidden = 1'b0;
`endif

    logic [9:0] dx, dy, idx_full, col_full;
    logic       in_field;
    logic [1:0] digit_idx;
    logic       digit_visible;
    logic       digit_lit;

    assign dx        = hsync - 10'(DIGIT_X0);
    assign dy        = vsync - 10'(DIGIT_Y0);
    assign idx_full  = dx / 10'(DIGIT_W);
    assign col_full  = dx % 10'(DIGIT_W);
    assign digit_idx = idx_full[1:0];
    assign in_field  = (hsync >= 10'(DIGIT_X0)) && (dx < 10'(FIELD_W)) &&
                       (vsync >= 10'(DIGIT_Y0)) && (dy < 10'(DIGIT_H));

    // Digit 0 is the thousands nibble; a digit shows once any digit at or above it is nonzero.
    always_comb begin
        font_digit    = 4'd0;
        font_row      = 5'd0;
        font_col      = 4'd0;
        digit_visible = 1'b1;
        if (in_field) begin
            font_row = dy[4:0];
            font_col = col_full[3:0];
            case (digit_idx)
                2'd0: begin
                    font_digit    = disp_bcd_q[15:12];
                    digit_visible = disp_bcd_q[15:12] != 4'd0;
                end
                2'd1: begin
                    font_digit    = disp_bcd_q[11:8];
                    digit_visible = disp_bcd_q[15:8] != 8'd0;
                end
                2'd2: begin
                    font_digit    = disp_bcd_q[7:4];
                    digit_visible = disp_bcd_q[15:4] != 12'd0;
                end
                default: begin
                    font_digit    = disp_bcd_q[3:0];
                    digit_visible = 1'b1;
                end
            endcase
        end
    end

    assign digit_lit = in_field && digit_visible && !digits_hidden && font_pixel;

    always_comb begin
        rgb_d = 24'h000000;
        if (digit_lit)               rgb_d = DIGIT_RGB;
        else if (label_rgb != 24'd0) rgb_d = label_rgb;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            score_q    <= '0;
            shift_q    <= '0;
            acc_q      <= '0;
            disp_bcd_q <= '0;
            bit_cnt_q  <= '0;
            rgb_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            score_q    <= score_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            disp_bcd_q <= disp_bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            rgb_q      <= rgb_d;
        end
    end

    assign rgb   = rgb_q;
    assign score = score_q;

endmodule

// File: tb/tb_score_hud_ctrl.sv
// Self-checking bench for score_hud_ctrl: vector table, directed corner sequences
// and random stimulus against a decimal-arithmetic reference model.
module tb_score_hud_ctrl;

    localparam int X0   = 640;
    localparam int Y0   = 118;
    localparam int DW   = 16;
    localparam int DH   = 24;
    localparam int MAXS = 9999;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start, hit_pulse, score_clr;
    logic [3:0]  hit_value;
    logic [9:0]  hsync, vsync;
    logic [23:0] label_rgb;
    logic [3:0]  font_digit;
    logic [4:0]  font_row;
    logic [3:0]  font_col;
    logic        font_pixel;
    logic [23:0] rgb;
    logic [13:0] score;
    logic        conv_busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: score, displayed value, snapshot, cycles until display update.
    int m_score = 0;
    int m_disp  = 0;
    int m_snap  = 0;
    int m_rem   = 0;

    score_hud_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .hit_pulse  (hit_pulse),
        .hit_value  (hit_value),
        .score_clr  (score_clr),
        .hsync      (hsync),
        .vsync      (vsync),
        .label_rgb  (label_rgb),
        .font_digit (font_digit),
        .font_row   (font_row),
        .font_col   (font_col),
        .font_pixel (font_pixel),
        .rgb        (rgb),
        .score      (score),
        .conv_busy  (conv_busy)
    );

    always #5 clk = ~clk;

    function automatic logic font_bit(input logic [3:0] d, input logic [4:0] r, input logic [3:0] c);
        int v;
        v = int'(d) * 5 + int'(r) * 3 + int'(c) * 7;
        return (v % 4) == 1;
    endfunction

    assign font_pixel = font_bit(font_digit, font_row, font_col);

    function automatic int pow10(input int k);
        int p;
        p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        return p;
    endfunction

    function automatic int exp_digit(input int v, input int i);
        return (v / pow10(3 - i)) % 10;
    endfunction

    function automatic bit in_field(input int x, input int y);
        return (x >= X0) && (x < X0 + 4 * DW) && (y >= Y0) && (y < Y0 + DH);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock, updating the model from the inputs seen at this edge.
    task automatic step();
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_disp = m_snap;
        end else if (frame_start) begin
            m_snap = m_score;
            m_rem  = 15;
        end
        if (score_clr) m_score = 0;
        else if (hit_pulse) m_score = (m_score + int'(hit_value) > MAXS) ? MAXS : m_score + int'(hit_value);
        @(posedge clk);
        #1;
    endtask

    task automatic check_pixel(input int x, input int y, input logic [23:0] label);
        int i, d, r, c;
        logic [23:0] e;
        hsync     = 10'(x);
        vsync     = 10'(y);
        label_rgb = label;
        #1;
        e = label;
        if (in_field(x, y)) begin
            i = (x - X0) / DW;
            c = (x - X0) % DW;
            r = y - Y0;
            d = exp_digit(m_disp, i);
            check("font_digit", 32'(font_digit), d);
            check("font_row", 32'(font_row), r);
            check("font_col", 32'(font_col), c);
            if (((i == 3) || (m_disp >= pow10(3 - i))) && font_bit(4'(d), 5'(r), 4'(c)))
                e = 24'hFFFF00;
        end else begin
            check("font_out_zero", {font_digit, font_row, font_col}, 0);
        end
        step();
        check("rgb", 32'(rgb), 32'(e));
    endtask

    task automatic scan_field();
        for (int y = Y0 - 1; y <= Y0 + DH; y++)
            for (int x = X0 - 2; x <= X0 + 4 * DW + 1; x++)
                check_pixel(x, y, ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'h0);
    endtask

    task automatic check_disp(input int v);
        for (int i = 0; i < 4; i++) begin
            hsync = 10'(X0 + i * DW + 3);
            vsync = 10'(Y0 + 5);
            #1;
            check("disp_digit", 32'(font_digit), exp_digit(v, i));
        end
    endtask

    task automatic convert();
        int n;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        n = 0;
        while (conv_busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
        check("busy_len", n, 15);
        check("conv_done", 32'(conv_busy), 0);
    endtask

    task automatic set_hit(input logic p, input int v, input logic clr);
        hit_pulse = p;
        hit_value = 4'(v);
        score_clr = clr;
    endtask

    typedef struct {
        logic hit;
        int   val;
        logic clr;
        int   exp_score;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 7, 1'b0, 7};
        vecs[1] = '{1'b1, 9, 1'b0, 16};
        vecs[2] = '{1'b1, 15, 1'b0, 31};
        vecs[3] = '{1'b0, 5, 1'b0, 31};
        vecs[4] = '{1'b1, 15, 1'b1, 0};
        vecs[5] = '{1'b1, 3, 1'b0, 3};
        vecs[6] = '{1'b1, 0, 1'b0, 3};
        vecs[7] = '{1'b0, 0, 1'b1, 0};

        rst = 1'b1;
        frame_start = 1'b0;
        set_hit(1'b0, 0, 1'b0);
        hsync = '0;
        vsync = '0;
        label_rgb = '0;
        #12;
        check("rst_score", 32'(score), 0);
        check("rst_busy", 32'(conv_busy), 0);
        check("rst_rgb", 32'(rgb), 0);
        rst = 1'b0;
        #1;

        // Reset display: only the units "0" glyph is drawn.
        convert();
        check_disp(0);
        scan_field();

        // Hit accumulation, then a conversion of 31.
        for (int k = 0; k < 4; k++) begin
            set_hit(vecs[k].hit, vecs[k].val, vecs[k].clr);
            step();
            check("vec_score", 32'(score), vecs[k].exp_score);
        end
        set_hit(1'b0, 0, 1'b0);
        convert();
        check_disp(31);
        scan_field();

        // Clear priority and small updates.
        for (int k = 4; k < 8; k++) begin
            set_hit(vecs[k].hit, vecs[k].val, vecs[k].clr);
            step();
            check("vec_score", 32'(score), vecs[k].exp_score);
        end

        // Saturation at 9999.
        set_hit(1'b1, 15, 1'b0);
        for (int k = 0; k < 666; k++) step();
        set_hit(1'b1, 5, 1'b0);
        step();
        check("sat_9995", 32'(score), 9995);
        set_hit(1'b1, 15, 1'b0);
        step();
        check("sat_9999", 32'(score), 9999);
        set_hit(1'b1, 1, 1'b0);
        step();
        check("sat_hold1", 32'(score), 9999);
        set_hit(1'b1, 15, 1'b0);
        step();
        check("sat_hold15", 32'(score), 9999);
        set_hit(1'b0, 0, 1'b0);
        convert();
        check_disp(9999);
        for (int x = X0 - 1; x <= X0 + 4 * DW; x++) check_pixel(x, Y0 + 7, 24'h0);

        // Hit during a conversion reaches the display only on the next frame.
        set_hit(1'b0, 0, 1'b1);
        step();
        set_hit(1'b1, 3, 1'b0);
        step();
        set_hit(1'b0, 0, 1'b0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int k = 0; k < 3; k++) step();
        set_hit(1'b1, 4, 1'b0);
        step();
        set_hit(1'b0, 0, 1'b0);
        check("mid_conv_score", 32'(score), 7);
        for (int k = 0; k < 40 && conv_busy === 1'b1; k++) step();
        check("mid_conv_done", 32'(conv_busy), 0);
        check_disp(3);
        convert();
        check_disp(7);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            hit_pulse   = ($urandom_range(0, 2) == 0);
            hit_value   = 4'($urandom_range(0, 15));
            score_clr   = ($urandom_range(0, 59) == 0);
            frame_start = ($urandom_range(0, 9) == 0);
            check_pixel(int'($urandom_range(X0 - 4, X0 + 4 * DW + 3)),
                        int'($urandom_range(Y0 - 3, Y0 + DH + 2)),
                        ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'h0);
            check("rnd_score", 32'(score), m_score);
            check("rnd_busy", 32'(conv_busy), (m_rem > 0) ? 1 : 0);
        end
        frame_start = 1'b0;
        set_hit(1'b0, 0, 1'b0);
        for (int k = 0; k < 40 && conv_busy === 1'b1; k++) step();
        check("rnd_drain", 32'(conv_busy), 0);

        // Asynchronous reset in the middle of a conversion.
        set_hit(1'b0, 0, 1'b1);
        step();
        set_hit(1'b1, 9, 1'b0);
        step();
        set_hit(1'b1, 15, 1'b0);
        step();
        set_hit(1'b0, 0, 1'b0);
        convert();
        check_disp(24);
        frame_start = 1'b1;
        check_pixel(10, 10, 24'hABCDEF);
        frame_start = 1'b0;
        for (int k = 0; k < 4; k++) check_pixel(10, 10, 24'hABCDEF);
        check("pre_rst_busy", 32'(conv_busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_rgb", 32'(rgb), 0);
        check("arst_busy", 32'(conv_busy), 0);
        check("arst_score", 32'(score), 0);
        m_score = 0;
        m_disp  = 0;
        m_rem   = 0;
        m_snap  = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_disp(0);
        check_pixel(100, 200, 24'h123456);
        check_pixel(10, 10, 24'h000000);
        for (int x = X0 + 3 * DW; x < X0 + 4 * DW; x++) check_pixel(x, Y0 + 3, 24'h00FF00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
